// File: rtl/voice_pkg.sv
// voice_pkg: shared envelope state encoding, level ceiling and rate-code to step conversion.
package voice_pkg;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } env_state_t;
   localparam logic [15:0] ENV_MAX = 16'hFFFF;
   // step = (r+1)*16, so code 0 still moves the level by 16 per tick
   function automatic logic [12:0] rate_step(input logic [7:0] r);
      return {9'(r) + 9'd1, 4'd0};
   endfunction
endpackage

// File: rtl/adsr_core.sv
// adsr_core: linear ADSR state machine and 16-bit level register, one step per sample edge.
//   sample_clock, rst_n : sample clock, async active-low reset
//   en                  : high once the parent's reset synchronizer has released
//   gate                : note on/off
//   *_rate, sustain_level : rate codes and sustain level code, sampled every edge
//   level, state, active  : registered envelope level, state and not-IDLE flag
module adsr_core import voice_pkg::*; (
   input  logic        sample_clock,
   input  logic        rst_n,
   input  logic        en,
   input  logic        gate,
   input  logic [7:0]  attack_rate,
   input  logic [7:0]  decay_rate,
   input  logic [7:0]  sustain_level,
   input  logic [7:0]  release_rate,
   output logic [15:0] level,
   output env_state_t  state,
   output logic        active
);
   // 17-bit arithmetic so neither end can wrap; both ends saturate instead
   logic [16:0] lvl, sa, sd, sr, tgt;
   always_comb begin
      lvl = {1'b0, level};
      sa  = {4'd0, rate_step(attack_rate)};
      sd  = {4'd0, rate_step(decay_rate)};
      sr  = {4'd0, rate_step(release_rate)};
      tgt = {1'b0, sustain_level, sustain_level};
   end
   always_ff @(posedge sample_clock or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         level  <= '0;
         active <= 1'b0;
      end else if (en) begin
         case (state)
            IDLE: if (gate) begin
               state  <= ATTACK;
               active <= 1'b1;
            end
            ATTACK: if (!gate) state <= RELEASE;
               else if (lvl + sa >= {1'b0, ENV_MAX}) begin
                  level <= ENV_MAX;
                  state <= DECAY;
               end else level <= 16'(lvl + sa);
            DECAY: if (!gate) state <= RELEASE;
               else if (lvl <= tgt + sd) begin
                  level <= 16'(tgt);
                  state <= SUSTAIN;
               end else level <= 16'(lvl - sd);
            SUSTAIN: if (!gate) state <= RELEASE;
               else level <= 16'(tgt);
            // a retrigger keeps the current level rather than restarting from 0
            RELEASE: if (gate) state <= ATTACK;
               else if (lvl <= sr) begin
                  level  <= '0;
                  state  <= IDLE;
                  active <= 1'b0;
               end else level <= 16'(lvl - sr);
            default: begin
               state  <= IDLE;
               active <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: rtl/voice_envelope.sv
// voice_envelope: per-voice ADSR envelope plus VCA scaling the oscillator about its midpoint.
//   sample_clock, rst_n : sample clock, async active-low reset (deassertion synchronized)
//   osc_in              : unsigned oscillator sample, midpoint 2^(BITDEPTH-1)
//   gate, *_rate, sustain_level : note gate and envelope controls
//   out                 : unsigned scaled sample, one edge after osc_in
//   env_level, env_state, active : registered envelope status
module voice_envelope import voice_pkg::*; #(
   parameter int BITDEPTH = 14
) (
   input  logic                sample_clock,
   input  logic                rst_n,
   input  logic [BITDEPTH-1:0] osc_in,
   input  logic                gate,
   input  logic [7:0]          attack_rate,
   input  logic [7:0]          decay_rate,
   input  logic [7:0]          sustain_level,
   input  logic [7:0]          release_rate,
   output logic [BITDEPTH-1:0] out,
   output logic [15:0]         env_level,
   output logic [2:0]          env_state,
   output logic                active
);
   localparam logic [BITDEPTH-1:0] MID = {1'b1, {(BITDEPTH-1){1'b0}}};
   logic [1:0] sync;
   logic [15:0] level, lvl_q;
   env_state_t st;
   logic signed [BITDEPTH-1:0] s_q;
   logic signed [BITDEPTH+16:0] prod;
   // asserts immediately, releases after two edges; the core steps from the second edge
   always_ff @(posedge sample_clock or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else sync <= {sync[0], 1'b1};
   end
   adsr_core u_core (
      .sample_clock (sample_clock),
      .rst_n        (rst_n),
      .en           (sync[0]),
      .gate         (gate),
      .attack_rate  (attack_rate),
      .decay_rate   (decay_rate),
      .sustain_level(sustain_level),
      .release_rate (release_rate),
      .level        (level),
      .state        (st),
      .active       (active)
   );
   assign env_level = level;
   assign env_state = st;
   // level is zero-extended to 17 bits so the product stays a signed x non-negative multiply
   assign prod = (BITDEPTH+17)'(s_q) * (BITDEPTH+17)'($signed({1'b0, lvl_q}));
   // stage 1 captures the offset-removed sample with the pre-update level; stage 2 scales it
   always_ff @(posedge sample_clock or negedge rst_n) begin
      if (!rst_n) begin
         s_q   <= '0;
         lvl_q <= '0;
         out   <= MID;
      end else if (sync[1]) begin
         s_q   <= $signed(osc_in ^ MID);
         lvl_q <= level;
         out   <= BITDEPTH'(prod >>> 16) ^ MID;
      end
   end
endmodule

// File: tb/tb_voice_envelope.sv
// tb_voice_envelope: table vectors, corner sequences and random stimulus against a behavioural model.
module tb_voice_envelope;
   localparam int BD = 14;
   localparam int MIDV = 1 << (BD - 1);
   logic sample_clock = 1'b0;
   logic rst_n = 1'b1;
   logic gate = 1'b0;
   logic [BD-1:0] osc_in = '0;
   logic [7:0] attack_rate = '0, decay_rate = '0, sustain_level = '0, release_rate = '0;
   logic [BD-1:0] out;
   logic [15:0] env_level;
   logic [2:0] env_state;
   logic active;
   int checks = 0, errors = 0;
   int m_state, m_level, m_osc_q, m_lvl_q, m_out, m_sync;
   typedef struct {
      logic g;
      logic [7:0] ar, dr, sl, rr;
      int lvl;
      int st;
      logic act;
   } vec_t;
   vec_t vecs[$];
   voice_envelope #(.BITDEPTH(BD)) dut (
      .sample_clock (sample_clock),
      .rst_n        (rst_n),
      .osc_in       (osc_in),
      .gate         (gate),
      .attack_rate  (attack_rate),
      .decay_rate   (decay_rate),
      .sustain_level(sustain_level),
      .release_rate (release_rate),
      .out          (out),
      .env_level    (env_level),
      .env_state    (env_state),
      .active       (active)
   );
   always #5 sample_clock = ~sample_clock;
   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   function automatic void check(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endfunction
   // out = mid + floor((osc - mid) * level / 65536)
   function automatic int vca(int osc, int lvl);
      longint p;
      p = longint'(osc - MIDV) * longint'(lvl);
      p = (p < 0) ? -((-p + 65535) / 65536) : p / 65536;
      return int'(p) + MIDV;
   endfunction
   function automatic vec_t mk(logic g, logic [7:0] ar, dr, sl, rr, int lvl, int st, logic act);
      vec_t v;
      v.g = g; v.ar = ar; v.dr = dr; v.sl = sl; v.rr = rr;
      v.lvl = lvl; v.st = st; v.act = act;
      return v;
   endfunction
   task automatic model_reset();
      m_state = 0; m_level = 0; m_osc_q = MIDV; m_lvl_q = 0; m_out = MIDV; m_sync = 0;
   endtask
   task automatic model_edge();
      int sa, sd, sr, tgt;
      sa = (int'(attack_rate) + 1) * 16;
      sd = (int'(decay_rate) + 1) * 16;
      sr = (int'(release_rate) + 1) * 16;
      tgt = int'(sustain_level) * 257;
      m_out = vca(m_osc_q, m_lvl_q);
      m_osc_q = int'(osc_in);
      m_lvl_q = m_level;
      if (m_sync == 0) m_sync = 1;
      else if (m_state == 0) m_state = gate ? 1 : 0;
      else if (!gate && m_state != 4) m_state = 4;
      else if (m_state == 1) begin
         m_level = m_level + sa;
         if (m_level >= 65535) begin m_level = 65535; m_state = 2; end
      end else if (m_state == 2) begin
         if (m_level <= tgt + sd) begin m_level = tgt; m_state = 3; end
         else m_level = m_level - sd;
      end else if (m_state == 3) m_level = tgt;
      else if (gate) m_state = 1;
      else if (m_level <= sr) begin m_level = 0; m_state = 0; end
      else m_level = m_level - sr;
   endtask
   task automatic tick();
      @(posedge sample_clock);
      model_edge();
      @(negedge sample_clock);
      check("out", out, m_out);
      check("env_level", env_level, m_level);
      check("env_state", env_state, m_state);
      check("active", active, m_state != 0);
   endtask
   task automatic apply(vec_t v, string tag);
      gate = v.g; attack_rate = v.ar; decay_rate = v.dr; sustain_level = v.sl; release_rate = v.rr;
      osc_in = BD'($urandom);
      tick();
      check({tag, " level"}, env_level, v.lvl);
      check({tag, " state"}, env_state, v.st);
      check({tag, " active"}, active, v.act);
   endtask
   initial begin
      int n;
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      check("reset out", out, 8192);
      check("reset level", env_level, 0);
      check("reset state", env_state, 0);
      check("reset active", active, 0);
      @(negedge sample_clock);
      rst_n = 1'b1;
      repeat (3) begin
         osc_in = BD'($urandom);
         tick();
         check("idle out", out, 8192);
      end
      // attack ramp, decay onto 0x8080, sustain, live sustain change
      vecs.push_back(mk(1, 8'hFF, 8'hFF, 8'h80, 8'h00, 0, 1, 1));
      for (int k = 1; k <= 15; k++) vecs.push_back(mk(1, 8'hFF, 8'hFF, 8'h80, 8'h00, 4096 * k, 1, 1));
      vecs.push_back(mk(1, 8'hFF, 8'hFF, 8'h80, 8'h00, 65535, 2, 1));
      for (int k = 1; k <= 7; k++) vecs.push_back(mk(1, 8'hFF, 8'hFF, 8'h80, 8'h00, 65535 - 4096 * k, 2, 1));
      vecs.push_back(mk(1, 8'hFF, 8'hFF, 8'h80, 8'h00, 32896, 3, 1));
      vecs.push_back(mk(1, 8'hFF, 8'hFF, 8'h80, 8'h00, 32896, 3, 1));
      vecs.push_back(mk(1, 8'hFF, 8'hFF, 8'h40, 8'h00, 16448, 3, 1));
      vecs.push_back(mk(0, 8'hFF, 8'hFF, 8'h40, 8'h00, 16448, 4, 1));
      foreach (vecs[i]) apply(vecs[i], "adsr");
      n = 0;
      while (env_level != 16'h2000 && n < 1000) begin
         tick();
         n++;
      end
      check("release edges to 0x2000", n, 516);
      // retrigger from 0x2000, then release to IDLE with step 4096
      vecs.delete();
      vecs.push_back(mk(1, 8'h00, 8'hFF, 8'h40, 8'h00, 8192, 1, 1));
      vecs.push_back(mk(1, 8'h00, 8'hFF, 8'h40, 8'h00, 8208, 1, 1));
      vecs.push_back(mk(0, 8'h00, 8'hFF, 8'h40, 8'hFF, 8208, 4, 1));
      vecs.push_back(mk(0, 8'h00, 8'hFF, 8'h40, 8'hFF, 4112, 4, 1));
      vecs.push_back(mk(0, 8'h00, 8'hFF, 8'h40, 8'hFF, 16, 4, 1));
      vecs.push_back(mk(0, 8'h00, 8'hFF, 8'h40, 8'hFF, 0, 0, 0));
      foreach (vecs[i]) apply(vecs[i], "retrig");
      // VCA extremes at full level
      gate = 1'b1; attack_rate = 8'hFF; decay_rate = 8'hFF; sustain_level = 8'hFF;
      repeat (20) tick();
      check("full level", env_level, 65535);
      check("full state", env_state, 3);
      osc_in = 14'd16383;
      tick();
      osc_in = 14'd0;
      tick();
      check("vca max", out, 16382);
      osc_in = 14'd5000;
      tick();
      check("vca min", out, 0);
      // reset in the middle of an attack
      gate = 1'b0; release_rate = 8'hFF;
      repeat (20) tick();
      gate = 1'b1; attack_rate = 8'h10;
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1;
      check("midreset out", out, 8192);
      check("midreset level", env_level, 0);
      check("midreset active", active, 0);
      model_reset();
      #1 rst_n = 1'b1;
      tick();
      check("post reset edge1 state", env_state, 0);
      tick();
      check("post reset edge2 state", env_state, 1);
      check("post reset edge2 level", env_level, 0);
      tick();
      check("post reset edge3 level", env_level, 272);
      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(39) == 0) gate = ~gate;
         if ($urandom_range(7) == 0) begin
            attack_rate = 8'($urandom); decay_rate = 8'($urandom);
            sustain_level = 8'($urandom); release_rate = 8'($urandom);
         end
         osc_in = BD'($urandom);
         tick();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/voice_envelope.md
# voice_envelope

Per-voice ADSR envelope generator and VCA, directly downstream of the `oscillator` stage. It takes the oscillator's unsigned waveform and a note gate, and runs a linear attack/decay/sustain/release envelope once per sample tick. It scales the waveform about its midpoint by the envelope level and hands the result to the voice mixer.

## Interface
Parameters:
- `BITDEPTH`, 14, sample width; must equal the oscillator's `BITDEPTH`.

Ports:
- `sample_clock` in 1: sample-rate clock; one envelope step and one output sample per rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `osc_in` in BITDEPTH: unsigned oscillator sample; midpoint is 2^(BITDEPTH-1).
- `gate` in 1: note on (1) / off (0), synchronous to `sample_clock`.
- `attack_rate` in 8: attack step code.
- `decay_rate` in 8: decay step code.
- `sustain_level` in 8: sustain level code.
- `release_rate` in 8: release step code.
- `out` out BITDEPTH: unsigned scaled sample.
- `env_level` out 16: current envelope level.
- `env_state` out 3: current state encoding.
- `active` out 1: high whenever the state is not IDLE.

## Operation
- Step for a rate code r: step = (r+1)*16, 13 bits, range 16..4096. Code 0 is therefore still a moving rate, never a hold.
- Sustain target: tgt = {sustain_level, sustain_level}, 16 bits (0x00 gives 0x0000, 0xFF gives 0xFFFF).
- Level is 16-bit unsigned. Arithmetic is done 17 bits wide, so there is no wrap-around; both ends saturate.
- States: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4. Exactly one transition is evaluated per edge.
  - IDLE: if gate=1, go to ATTACK; level stays unchanged on that edge.
  - ATTACK: if gate=0, go to RELEASE with level held. Otherwise, if level+step ≥ 0xFFFF, set level=0xFFFF and go to DECAY. Otherwise level += step.
  - DECAY: if gate=0, go to RELEASE with level held. Otherwise, if level ≤ tgt+step, set level=tgt and go to SUSTAIN. Otherwise level -= step. With tgt=0xFFFF the block reaches SUSTAIN on the first DECAY edge.
  - SUSTAIN: if gate=0, go to RELEASE. Otherwise level=tgt each edge, so the level tracks live `sustain_level` changes.
  - RELEASE: if gate=1, go to ATTACK as a retrigger with the level preserved (no reset to 0). Otherwise, if level ≤ step, set level=0 and go to IDLE. Otherwise level -= step.
- Rates are sampled on every edge, so a rate change takes effect on the next step.
- VCA datapath:
  - s = osc_in with its MSB inverted, giving a signed value in −2^(BITDEPTH-1)..2^(BITDEPTH-1)−1.
  - p = s × {0, level}: signed × 17-bit non-negative.
  - y = p >>> 16, an arithmetic shift that floors the result.
  - out = y with its MSB inverted.
  - Level 0 gives out = 2^(BITDEPTH-1) exactly. Full-scale input can never overflow.

## Timing
- Reset values (asynchronous on `rst_n` low): state IDLE, level 0, `env_level`=0, `env_state`=0, `active`=0, internal s register 0, `out`=2^(BITDEPTH-1).
- Release of `rst_n` is synchronized internally with a two-flop deassertion sync. The first state update happens on the second edge after deassertion.
- Reset asserted mid-note forces the full reset values immediately. After release, the block restarts from IDLE.
- `env_level`, `env_state` and `active` are registered and reflect the state after each edge.
- Pipeline stage 1, edge k: sample `osc_in` into s_q, and latch the pre-update level into lvl_q.
- Pipeline stage 2, edge k+1: `out` = f(s_q, lvl_q). Latency is one edge from `osc_in` to `out`, with the level aligned to the same edge.
- A gate change is acted on at the first edge where it is sampled. There is no extra gate latency.

## Structure
- Package `voice_pkg` holds:
  - `env_state_t`, an enum with the encodings above;
  - `ENV_MAX`=16'hFFFF;
  - the function `rate_step(r)`.
- Sub-module `adsr_core` contains the state machine and level register. The parent `voice_envelope` holds the reset synchronizer, the two-stage VCA pipeline and the offset conversion.
- The multiply is a single BITDEPTH×17 signed product and is inferred, not instantiated.

## Test plan
- Attack ramp: sustain_level=0x80, attack_rate=0xFF, gate=1 from IDLE.
  - Expect level 4096, 8192, …, 61440, then 0xFFFF on the 16th ATTACK edge, then DECAY.
- Decay and sustain: decay_rate=0xFF, sustain_level=0x80 (tgt=0x8080).
  - Expect level to fall by 4096 per edge and land exactly on 0x8080, then hold in SUSTAIN.
  - Changing sustain_level to 0x40 makes level 0x4040 on the next edge.
- Release and retrigger: gate=0 in SUSTAIN with release_rate=0x00 (step 16). Expect a 16-per-edge decrement.
  - Raise gate at level 0x2000: expect ATTACK starting from 0x2000, not from 0.
  - Left low, the level reaches 0 and IDLE, and `active` drops on that same edge.
- VCA extremes, BITDEPTH=14:
  - level 0xFFFF, osc_in 16383 → out 16382; osc_in 0 → out 0.
  - level 0, any osc_in → out 8192.
  - Each result appears one edge after osc_in is presented.
- Reset mid-attack: pulse rst_n low between edges.
  - Expect out=8192, env_level=0 and active=0 immediately, without waiting for a clock.
  - After release, with gate still high, ATTACK resumes from 0 on the second edge after deassertion.
